// File: rtl/fft_reorder.sv
// FFT output reorder: ping-pong banks turn bit-reversed MDC pairs
// into natural-order bins, one bin per output transfer.
module fft_reorder #(
  parameter int WIDTH = 9,
  parameter int N     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_up_re,
  input  logic signed [WIDTH-1:0] in_up_im,
  input  logic signed [WIDTH-1:0] in_l_re,
  input  logic signed [WIDTH-1:0] in_l_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic [4:0]              out_index,
  output logic                    out_last
);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_st_t;

  bank_st_t st [2];

  logic       fill_ptr;
  logic       drain_ptr;
  logic [3:0] wr_cnt;
  logic [4:0] rd_cnt;

  logic signed [WIDTH-1:0] mem_re [2][N];
  logic signed [WIDTH-1:0] mem_im [2][N];

  logic       in_fire;
  logic       out_fire;
  logic [4:0] up_addr;
  logic [4:0] l_addr;

  function automatic logic [4:0] bitrev5(input logic [4:0] a);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

  assign in_ready  = (st[fill_ptr] == EMPTY) ||
                     (st[fill_ptr] == FILLING);
  assign out_valid = (st[drain_ptr] == FULL) ||
                     (st[drain_ptr] == DRAINING);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign up_addr = bitrev5({wr_cnt, 1'b0});
  assign l_addr  = bitrev5({wr_cnt, 1'b1});

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re[fill_ptr][up_addr] <= in_up_re;
      mem_im[fill_ptr][up_addr] <= in_up_im;
      mem_re[fill_ptr][l_addr]  <= in_l_re;
      mem_im[fill_ptr][l_addr]  <= in_l_im;
    end
  end

  // Fill and drain banks can never coincide, so both updates are safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      st[0]     <= EMPTY;
      st[1]     <= EMPTY;
      fill_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else begin
      if (in_fire) begin
        wr_cnt <= wr_cnt + 4'd1;
        if (wr_cnt == 4'd15) begin
          st[fill_ptr] <= FULL;
          fill_ptr     <= ~fill_ptr;
        end else begin
          st[fill_ptr] <= FILLING;
        end
      end
      if (out_fire) begin
        rd_cnt <= rd_cnt + 5'd1;
        if (rd_cnt == 5'd31) begin
          st[drain_ptr] <= EMPTY;
          drain_ptr     <= ~drain_ptr;
        end else begin
          st[drain_ptr] <= DRAINING;
        end
      end
    end
  end

  assign out_re    = out_valid ? mem_re[drain_ptr][rd_cnt] : '0;
  assign out_im    = out_valid ? mem_im[drain_ptr][rd_cnt] : '0;
  assign out_index = rd_cnt;
  assign out_last  = out_valid && (rd_cnt == 5'd31);

endmodule

// File: tb/tb_fft_reorder.sv
// Randomized bench for fft_reorder against a frame-queue model.
// Model tracks frames as lists of bins, not bank states.
module tb_fft_reorder;

  localparam int W = 9;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] in_up_re = '0;
  logic signed [W-1:0] in_up_im = '0;
  logic signed [W-1:0] in_l_re = '0;
  logic signed [W-1:0] in_l_im = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic [4:0]          out_index;
  logic                out_last;

  fft_reorder #(.WIDTH(W), .N(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_up_re (in_up_re),
    .in_up_im (in_up_im),
    .in_l_re  (in_l_re),
    .in_l_im  (in_l_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_index(out_index),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
  } ent_t;

  ent_t q[$];
  int   fre[32];
  int   fim[32];
  int   pcnt = 0;
  int   ridx = 0;
  int   mode = 0;
  int   lowcnt = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int brev(input int a);
    int r = 0;
    for (int i = 0; i < 5; i++)
      if ((a >> i) & 1) r += 1 << (4 - i);
    return r;
  endfunction

  function automatic int pick();
    return ($urandom_range(0, 1) == 1) ? -256 : 255;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic step(input bit v, input bit r, input bit rs);
    int nf;
    int k;
    ent_t e;
    @(posedge clk);
    #1;
    rst       = rs;
    in_valid  = v;
    out_ready = r;
    case (mode)
      0: begin
        in_up_re = W'(2 * pcnt);
        in_l_re  = W'(2 * pcnt + 1);
        in_up_im = W'(-2 * pcnt);
        in_l_im  = W'(-(2 * pcnt + 1));
      end
      1: begin
        in_up_re = W'(rnd());
        in_up_im = W'(rnd());
        in_l_re  = W'(rnd());
        in_l_im  = W'(rnd());
      end
      default: begin
        in_up_re = W'(pick());
        in_up_im = W'(pick());
        in_l_re  = W'(pick());
        in_l_im  = W'(pick());
      end
    endcase
    @(negedge clk);
    nf = (q.size() + 31) / 32;
    chk("in_ready", int'(in_ready), int'(nf < 2));
    chk("out_valid", int'(out_valid), int'(nf > 0));
    if (!in_ready) lowcnt++;
    if (nf > 0) begin
      e = q[0];
      chk("out_re", int'(out_re), e.re);
      chk("out_im", int'(out_im), e.im);
      chk("out_index", int'(out_index), ridx);
      chk("out_last", int'(out_last), int'(ridx == 31));
    end else begin
      chk("out_last_idle", int'(out_last), 0);
    end
    if (rs) begin
      q.delete();
      pcnt = 0;
      ridx = 0;
    end else begin
      if (nf > 0 && r) begin
        void'(q.pop_front());
        ridx = (ridx + 1) % 32;
      end
      if (v && nf < 2) begin
        k = pcnt;
        fre[brev(2 * k)]     = int'(in_up_re);
        fim[brev(2 * k)]     = int'(in_up_im);
        fre[brev(2 * k + 1)] = int'(in_l_re);
        fim[brev(2 * k + 1)] = int'(in_l_im);
        pcnt++;
        if (pcnt == 16) begin
          pcnt = 0;
          for (int i = 0; i < 32; i++) begin
            e.re = fre[i];
            e.im = fim[i];
            q.push_back(e);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    step(0, 1, 1);
    step(0, 1, 0);
    chk("rst_re", int'(out_re), 0);
    chk("rst_im", int'(out_im), 0);
    chk("rst_index", int'(out_index), 0);
    chk("rst_last", int'(out_last), 0);

    mode = 0;
    for (int i = 0; i < 16; i++) step(1, 1, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 0);

    mode = 1;
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, ($urandom % 3) != 0, 0);
    for (int i = 0; i < 80; i++) step(0, 1, 0);

    for (int i = 0; i < 16; i++) step(1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    for (int i = 0; i < 100; i++) step(1, 1, 0);
    for (int i = 0; i < 80; i++) step(0, 1, 0);

    mode = 0;
    for (int i = 0; i < 7; i++) step(1, 1, 0);
    step(0, 1, 1);
    for (int i = 0; i < 16; i++) step(1, 1, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 0);

    mode = 2;
    for (int i = 0; i < 16; i++) step(1, ($urandom % 2) != 0, 0);
    for (int i = 0; i < 60; i++) step(0, 1, 0);

    mode = 1;
    step(0, 1, 1);
    for (int i = 0; i < 64; i++) step(1, 1, 0);
    lowcnt = 0;
    for (int i = 0; i < 64; i++) step(1, 1, 0);
    chk("thru_low", lowcnt, 32);
    for (int i = 0; i < 80; i++) step(0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
